pkt_header_parser: RTL and testbench
====================================

Name: pkt_header_parser

Overview:
- Upstream stage of the node's forwarding check: consumes a 16-bit word stream, captures the packet header, launches the forwarding check on the extracted destination ID and gates the payload based on its result.
- Feeds the downstream checker (start/done/iamForwarding) and the payload sink.
- Same en/start/done task discipline as the other node stages.

Parameters:
- WORD_WIDTH, 16, width of the stream word and of node IDs.
- MAX_PAYLOAD, 32, largest legal payload length in words.
- CHK_TIMEOUT, 15, cycles allowed for the checker to return done.

Ports:
- clock  in  1  single clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- en  in  1  arms the parser from ST_WAIT_EN and clears the done/err flags.
- in_data  in  WORD_WIDTH  stream word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  parser accepts in_data this cycle.
- srcID  out  WORD_WIDTH  captured source ID.
- destinationID  out  WORD_WIDTH  captured destination ID, wired to the checker.
- pkt_type  out  8  captured type, word2[15:8].
- pkt_len  out  8  captured length, word2[7:0].
- chk_start  out  1  one-cycle pulse to the checker.
- chk_done  in  1  checker done.
- chk_fwd  in  1  checker iamForwarding, sampled when chk_done=1.
- fwd_flag  out  1  latched forwarding decision.
- pay_data  out  WORD_WIDTH  payload word, equal to in_data.
- pay_valid  out  1  payload word valid.
- pay_ready  in  1  sink accepts the payload word.
- err  out  1  length or timeout error, held until en.
- done  out  1  packet fully consumed, held until en.

Behaviour:
- Reset (nrst=0, asynchronous):
  - All outputs and registers go to 0.
  - State goes to ST_WAIT_EN.
  - Asserting reset in any state aborts the packet; a partial packet is not resumed.
- A word transfers only on a cycle with in_valid & in_ready.
- State machine:
  - ST_WAIT_EN: in_ready=0. On en=1, clear done, err and fwd_flag, then go to ST_SRC.
  - ST_SRC: in_ready=1. On transfer, srcID<=in_data, go to ST_DST.
  - ST_DST: in_ready=1. On transfer, destinationID<=in_data, go to ST_LEN.
  - ST_LEN: in_ready=1. On transfer, pkt_type<=in_data[15:8], pkt_len<=in_data[7:0], load pay_cnt<=in_data[7:0], go to ST_CHECK.
  - ST_CHECK:
    - in_ready=0.
    - chk_start=1 on the first cycle in the state only.
    - The timeout counter starts at 0 on entry and increments each cycle.
    - If chk_done=1: fwd_flag<=chk_fwd, go to ST_PAYLOAD.
    - Else if the counter reaches CHK_TIMEOUT: fwd_flag<=0, err<=1, go to ST_PAYLOAD.
    - If chk_done and the timeout occur in the same cycle, chk_done wins.
  - ST_PAYLOAD:
    - If pay_cnt==0 on entry, go to ST_DONE the next cycle with no transfer.
    - If fwd_flag=1 and pkt_len<=MAX_PAYLOAD: pay_valid=in_valid, in_ready=pay_ready, pay_data=in_data (combinational passthrough, zero latency).
    - Otherwise the payload is dropped: pay_valid=0, in_ready=1.
    - Each transfer decrements pay_cnt. The transfer that brings pay_cnt to 0 moves to ST_DONE.
  - ST_DONE: done=1 and in_ready=0. Wait for en=1, then clear done, err and fwd_flag and go to ST_SRC.
- Length error: pkt_len>MAX_PAYLOAD sets err<=1 at the ST_LEN→ST_CHECK transition. The check still runs, and the payload is drained (dropped) to stay word-aligned.
- Hold rules:
  - Header outputs hold their values until the next capture.
  - fwd_flag holds until it is cleared by en.
- Output hazards:
  - chk_start is never asserted outside the entry cycle of ST_CHECK.
  - pay_valid is never asserted outside ST_PAYLOAD.
- An en pulse outside ST_WAIT_EN and ST_DONE is ignored.
- Widths: pay_cnt is 8 bits. The timeout counter is 0 to CHK_TIMEOUT, sized by clog2(CHK_TIMEOUT+1).

Decomposition:
- Shared package node_pkg: WORD_WIDTH, state encodings (ST_WAIT_EN..ST_DONE, 3 bits), field slice constants TYPE_MSB/LSB and LEN_MSB/LEN_LSB.
- Sub-module pkt_down_counter: loadable 8-bit down counter with zero flag. It serves both pay_cnt and the timeout counter; for the timeout counter it is loaded with CHK_TIMEOUT and counts down to zero.
- The top level holds the FSM and the passthrough muxing.

Test Plan:
- Reset then en. Words 0x0001, 0x0005, 0x0A03; checker answers chk_done=1, chk_fwd=1 two cycles after chk_start; 3 payload words, pay_ready=1.
  -> srcID=1, destinationID=5, pkt_type=0x0A, pkt_len=3; exactly one chk_start pulse; 3 pay_valid beats with matching data; done=1, err=0.
- Same packet with chk_fwd=0.
  -> fwd_flag=0, pay_valid never high; 3 words consumed with in_ready=1; done=1.
- Length word 0x0021 (33 > MAX_PAYLOAD) with chk_fwd=1.
  -> err=1 after ST_LEN; all 33 words dropped; done=1.
- Checker never answers.
  -> err=1 and fwd_flag=0 after 15 cycles in ST_CHECK; payload dropped; done=1.
- pay_ready toggling 1,0,0,1,1 and in_valid gapped during payload.
  -> transfers occur only on cycles with in_valid & pay_ready; word order is preserved; pay_cnt reaches 0 exactly at the final word.
- Two further cases:
  - Length 0 -> done one cycle after entering ST_PAYLOAD.
  - nrst pulsed mid-payload -> all outputs 0 immediately; state ST_WAIT_EN; next en starts a clean header.

Source files
------------

// File: rtl/pkt_header_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : node_pkg
// Description : Shared node constants, header field slices and parser states.
// Revision    : 1.0 - initial release
// ============================================================================
package node_pkg;

    localparam int WORD_WIDTH = 16;

    // Third header word carries {type, length}
    localparam int TYPE_MSB = 15;
    localparam int TYPE_LSB = 8;
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 0;

    typedef enum logic [2:0] {
        ST_WAIT_EN = 3'd0,
        ST_SRC     = 3'd1,
        ST_DST     = 3'd2,
        ST_LEN     = 3'd3,
        ST_CHECK   = 3'd4,
        ST_PAYLOAD = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

endpackage : node_pkg
`default_nettype wire

// File: rtl/pkt_header_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : pkt_header_parser_if
// Description : Stream, checker, payload and status bundle of the parser.
// Revision    : 1.0 - initial release
// ============================================================================
interface pkt_header_parser_if #(
    parameter int WORD_WIDTH = node_pkg::WORD_WIDTH
);
    logic                  en;
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] srcID;
    logic [WORD_WIDTH-1:0] destinationID;
    logic [7:0]            pkt_type;
    logic [7:0]            pkt_len;
    logic                  chk_start;
    logic                  chk_done;
    logic                  chk_fwd;
    logic                  fwd_flag;
    logic [WORD_WIDTH-1:0] pay_data;
    logic                  pay_valid;
    logic                  pay_ready;
    logic                  err;
    logic                  done;

    modport slave (
        input  en, in_data, in_valid, chk_done, chk_fwd, pay_ready,
        output in_ready, srcID, destinationID, pkt_type, pkt_len,
               chk_start, fwd_flag, pay_data, pay_valid, err, done
    );

    modport master (
        output en, in_data, in_valid, chk_done, chk_fwd, pay_ready,
        input  in_ready, srcID, destinationID, pkt_type, pkt_len,
               chk_start, fwd_flag, pay_data, pay_valid, err, done
    );

endinterface : pkt_header_parser_if
`default_nettype wire

// File: rtl/pkt_header_parser_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : pkt_down_counter
// Description : Loadable down counter with zero flag; load wins over dec and
//               the caller never decrements at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_down_counter #(
    parameter int WIDTH = 8
) (
    input  wire logic             clock,
    input  wire logic             nrst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             dec,
    output logic      [WIDTH-1:0] count,
    output logic                  zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule : pkt_down_counter
`default_nettype wire

// File: rtl/pkt_header_parser.sv
`default_nettype none
// ============================================================================
// Module      : pkt_header_parser
// Description : Captures the 3-word header, runs the forwarding check on the
//               destination ID and passes or drops the payload accordingly.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_header_parser #(
    parameter int WORD_WIDTH  = node_pkg::WORD_WIDTH,
    parameter int MAX_PAYLOAD = 32,
    parameter int CHK_TIMEOUT = 15
) (
    input wire logic            clock,
    input wire logic            nrst,
    pkt_header_parser_if.slave  bus
);
    import node_pkg::*;

    localparam int                 c_TMO_W    = $clog2(CHK_TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LOAD = c_TMO_W'(CHK_TIMEOUT);
    localparam logic [7:0]         c_MAX_LEN  = 8'(MAX_PAYLOAD);

    state_t                r_state;
    logic [WORD_WIDTH-1:0] r_src;
    logic [WORD_WIDTH-1:0] r_dst;
    logic [7:0]            r_type;
    logic [7:0]            r_len;
    logic                  r_chk_start;
    logic                  r_fwd;
    logic                  r_err;
    logic                  r_done;

    logic                  w_in_ready;
    logic                  w_xfer;
    logic                  w_pass;
    logic [7:0]            w_len_field;
    logic                  w_hdr_load;
    logic                  w_pay_dec;
    logic [7:0]            w_pay_cnt;
    logic                  w_pay_zero;
    logic                  w_tmo_dec;
    logic [c_TMO_W-1:0]    w_tmo_cnt;
    logic                  w_tmo_zero;

    assign w_len_field = bus.in_data[LEN_MSB:LEN_LSB];
    assign w_xfer      = bus.in_valid && w_in_ready;
    assign w_pass      = r_fwd && (r_len <= c_MAX_LEN);
    assign w_hdr_load  = (r_state == ST_LEN) && w_xfer;
    assign w_pay_dec   = (r_state == ST_PAYLOAD) && w_xfer;
    assign w_tmo_dec   = (r_state == ST_CHECK) && (w_tmo_cnt != '0);

    // Both counters are loaded by the length word, so the timeout window
    // opens exactly on the entry cycle of ST_CHECK.
    pkt_down_counter #(
        .WIDTH(8)
    ) u_pay_cnt (
        .clock   (clock),
        .nrst    (nrst),
        .load    (w_hdr_load),
        .load_val(w_len_field),
        .dec     (w_pay_dec),
        .count   (w_pay_cnt),
        .zero    (w_pay_zero)
    );

    pkt_down_counter #(
        .WIDTH(c_TMO_W)
    ) u_tmo_cnt (
        .clock   (clock),
        .nrst    (nrst),
        .load    (w_hdr_load),
        .load_val(c_TMO_LOAD),
        .dec     (w_tmo_dec),
        .count   (w_tmo_cnt),
        .zero    (w_tmo_zero)
    );

    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            ST_SRC, ST_DST, ST_LEN: w_in_ready = 1'b1;
            ST_PAYLOAD: begin
                // Forwarded payload is throttled by the sink; dropped payload drains freely
                if (!w_pay_zero) begin
                    w_in_ready = w_pass ? bus.pay_ready : 1'b1;
                end
            end
            default: w_in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_state     <= ST_WAIT_EN;
            r_src       <= '0;
            r_dst       <= '0;
            r_type      <= '0;
            r_len       <= '0;
            r_chk_start <= 1'b0;
            r_fwd       <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_chk_start <= 1'b0;
            case (r_state)
                ST_WAIT_EN: begin
                    if (bus.en) begin
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_fwd   <= 1'b0;
                        r_state <= ST_SRC;
                    end
                end
                ST_SRC: begin
                    if (w_xfer) begin
                        r_src   <= bus.in_data;
                        r_state <= ST_DST;
                    end
                end
                ST_DST: begin
                    if (w_xfer) begin
                        r_dst   <= bus.in_data;
                        r_state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (w_xfer) begin
                        r_type      <= bus.in_data[TYPE_MSB:TYPE_LSB];
                        r_len       <= w_len_field;
                        r_chk_start <= 1'b1;
                        if (w_len_field > c_MAX_LEN) begin
                            r_err <= 1'b1;
                        end
                        r_state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (bus.chk_done) begin
                        r_fwd   <= bus.chk_fwd;
                        r_state <= ST_PAYLOAD;
                    end else if (w_tmo_zero) begin
                        r_fwd   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_pay_zero || (w_xfer && (w_pay_cnt == 8'd1))) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.en) begin
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_fwd   <= 1'b0;
                        r_state <= ST_SRC;
                    end
                end
                default: r_state <= ST_WAIT_EN;
            endcase
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.srcID         = r_src;
    assign bus.destinationID = r_dst;
    assign bus.pkt_type      = r_type;
    assign bus.pkt_len       = r_len;
    assign bus.chk_start     = r_chk_start;
    assign bus.fwd_flag      = r_fwd;
    assign bus.err           = r_err;
    assign bus.done          = r_done;
    assign bus.pay_data      = bus.in_data;
    assign bus.pay_valid     = (r_state == ST_PAYLOAD) && !w_pay_zero && w_pass && bus.in_valid;

endmodule : pkt_header_parser
`default_nettype wire

// File: tb/tb_pkt_header_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_header_parser
// Description : Randomised packet bench with a phase-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_header_parser;

    localparam logic [7:0] MAXP = 8'd32;
    localparam int TMO    = 15;
    localparam int P_IDLE = 0, P_HDR = 1, P_CHK = 2, P_PAY = 3, P_FIN = 4;

    logic clock = 1'b0;
    logic nrst;
    always #5 clock = ~clock;

    pkt_header_parser_if #(.WORD_WIDTH(16)) bus ();

    pkt_header_parser #(
        .WORD_WIDTH (16),
        .MAX_PAYLOAD(32),
        .CHK_TIMEOUT(15)
    ) dut (
        .clock(clock),
        .nrst (nrst),
        .bus  (bus)
    );

    // Reference model: where the packet is and what the outputs must be
    int          m_ph, m_hidx, m_chkcyc, m_rem, m_pidx;
    logic [15:0] m_src, m_dst;
    logic [7:0]  m_typ, m_len;
    logic        m_first, m_fwd, m_err, m_done, m_pass;

    logic [15:0] hdr [3];
    logic [15:0] pl [$];
    logic [15:0] rx [$];
    int          n_start;
    int          total = 0;
    int          bad   = 0;
    int          rdy_pat [5] = '{1, 0, 0, 1, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_in_ready();
        if (m_ph == P_HDR) return 1'b1;
        if (m_ph == P_PAY && m_rem != 0) return m_pass ? bus.pay_ready : 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_pay_valid();
        return (m_ph == P_PAY) && (m_rem != 0) && m_pass && bus.in_valid;
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_hidx = 0; m_chkcyc = 0; m_rem = 0; m_pidx = 0;
        m_src = '0; m_dst = '0; m_typ = '0; m_len = '0;
        m_first = 0; m_fwd = 0; m_err = 0; m_done = 0; m_pass = 0;
    endtask

    task automatic enter_pay();
        m_ph   = P_PAY;
        m_rem  = int'(m_len);
        m_pidx = 0;
        m_pass = m_fwd && (m_len <= MAXP);
    endtask

    // Advance the model by one clock using the inputs that edge sampled
    task automatic model_step();
        case (m_ph)
            P_IDLE, P_FIN: if (bus.en) begin
                m_ph = P_HDR; m_hidx = 0; m_done = 0; m_err = 0; m_fwd = 0;
            end
            P_HDR: if (bus.in_valid) begin
                if (m_hidx == 0) m_src = bus.in_data;
                else if (m_hidx == 1) m_dst = bus.in_data;
                else begin
                    m_typ = bus.in_data[15:8];
                    m_len = bus.in_data[7:0];
                    if (m_len > MAXP) m_err = 1'b1;
                    m_ph = P_CHK; m_first = 1'b1; m_chkcyc = 0;
                end
                m_hidx++;
            end
            P_CHK: begin
                m_first = 1'b0;
                if (bus.chk_done) begin
                    m_fwd = bus.chk_fwd; enter_pay();
                end else if (m_chkcyc == TMO) begin
                    m_fwd = 1'b0; m_err = 1'b1; enter_pay();
                end else begin
                    m_chkcyc++;
                end
            end
            P_PAY: begin
                if (m_rem == 0) begin
                    m_ph = P_FIN; m_done = 1'b1;
                end else if (bus.in_valid && exp_in_ready()) begin
                    m_rem--; m_pidx++;
                    if (m_rem == 0) begin m_ph = P_FIN; m_done = 1'b1; end
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (nrst) model_step();
    endtask

    always @(negedge clock) begin
        chk("in_ready",      32'(bus.in_ready),      32'(exp_in_ready()));
        chk("pay_valid",     32'(bus.pay_valid),     32'(exp_pay_valid()));
        chk("chk_start",     32'(bus.chk_start),     32'(m_ph == P_CHK && m_first));
        chk("done",          32'(bus.done),          32'(m_done));
        chk("err",           32'(bus.err),           32'(m_err));
        chk("fwd_flag",      32'(bus.fwd_flag),      32'(m_fwd));
        chk("srcID",         32'(bus.srcID),         32'(m_src));
        chk("destinationID", 32'(bus.destinationID), 32'(m_dst));
        chk("pkt_type",      32'(bus.pkt_type),      32'(m_typ));
        chk("pkt_len",       32'(bus.pkt_len),       32'(m_len));
        if (exp_pay_valid()) chk("pay_data", 32'(bus.pay_data), 32'(pl[m_pidx]));
        if (bus.chk_start) n_start++;
        if (bus.pay_valid && bus.pay_ready) rx.push_back(bus.pay_data);
    end

    task automatic quiet();
        bus.en = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.chk_done = 1'b0; bus.chk_fwd = 1'b0; bus.pay_ready = 1'b0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        model_reset();
        quiet();
        #1;
        chk("rst_async_src",  32'(bus.srcID),     32'h0);
        chk("rst_async_pv",   32'(bus.pay_valid), 32'h0);
        chk("rst_async_fwd",  32'(bus.fwd_flag),  32'h0);
        tick();
        tick();
        nrst = 1'b1;
    endtask

    // mode 0: always valid/ready; 1: random; 2: fixed ready toggle, gapped valid
    task automatic run_packet(input logic [15:0] src, input logic [15:0] dst,
                              input logic [7:0] typ, input logic [7:0] len,
                              input int rsp_delay, input logic fwd,
                              input int mode, input int abort_at);
        int guard;
        int pcyc;
        int exp_n;
        logic order_ok;
        pl.delete();
        for (int i = 0; i < int'(len); i++) pl.push_back(16'($urandom));
        hdr[0] = src; hdr[1] = dst; hdr[2] = {typ, len};
        rx.delete(); n_start = 0; pcyc = 0; guard = 0;

        quiet();
        bus.en = 1'b1;
        tick();
        while (m_ph != P_FIN && guard < 3000) begin
            bus.en        = ($urandom_range(0, 7) == 0);
            bus.chk_done  = 1'b0;
            bus.chk_fwd   = 1'($urandom);
            bus.in_valid  = 1'b0;
            bus.in_data   = 16'($urandom);
            bus.pay_ready = 1'($urandom);
            case (m_ph)
                P_HDR: begin
                    bus.in_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    if (bus.in_valid) bus.in_data = hdr[m_hidx];
                end
                P_CHK: begin
                    bus.in_valid = 1'($urandom);
                    bus.chk_done = (m_chkcyc == rsp_delay);
                    if (bus.chk_done) bus.chk_fwd = fwd;
                end
                P_PAY: begin
                    if (abort_at >= 0 && pcyc == abort_at) begin
                        do_reset();
                        return;
                    end
                    if (mode == 0) begin
                        bus.in_valid = 1'b1; bus.pay_ready = 1'b1;
                    end else if (mode == 1) begin
                        bus.in_valid = ($urandom_range(0, 9) < 7);
                    end else begin
                        bus.in_valid  = ((pcyc % 3) != 2);
                        bus.pay_ready = (rdy_pat[pcyc % 5] != 0);
                    end
                    if (bus.in_valid && m_pidx < pl.size()) bus.in_data = pl[m_pidx];
                    pcyc++;
                end
                default: ;
            endcase
            guard++;
            tick();
        end
        quiet();
        if (guard >= 3000) begin
            total++; bad++;
            $display("FAIL packet_timeout: no completion within 3000 cycles");
        end
        exp_n = m_pass ? int'(len) : 0;
        chk("payload_count", 32'(rx.size()), 32'(exp_n));
        order_ok = (rx.size() == exp_n);
        for (int i = 0; i < rx.size() && i < exp_n; i++)
            if (rx[i] !== pl[i]) order_ok = 1'b0;
        chk("payload_order", 32'(order_ok), 32'h1);
    endtask

    initial begin
        logic [7:0] rlen;
        nrst = 1'b0;
        model_reset();
        quiet();
        tick();
        tick();
        chk("reset_in_ready", 32'(bus.in_ready), 32'h0);
        chk("reset_done",     32'(bus.done),     32'h0);
        nrst = 1'b1;
        tick();

        // Basic forwarded packet
        run_packet(16'h0001, 16'h0005, 8'h0A, 8'd3, 2, 1'b1, 0, -1);
        chk("p1_src",    32'(bus.srcID),         32'h1);
        chk("p1_dst",    32'(bus.destinationID), 32'h5);
        chk("p1_type",   32'(bus.pkt_type),      32'h0A);
        chk("p1_len",    32'(bus.pkt_len),       32'h3);
        chk("p1_starts", 32'(n_start),           32'h1);
        chk("p1_beats",  32'(rx.size()),         32'h3);
        chk("p1_done",   32'(bus.done),          32'h1);
        chk("p1_err",    32'(bus.err),           32'h0);

        // Not forwarded: payload drained
        run_packet(16'h0001, 16'h0005, 8'h0A, 8'd3, 2, 1'b0, 0, -1);
        chk("p2_fwd",   32'(bus.fwd_flag), 32'h0);
        chk("p2_beats", 32'(rx.size()),    32'h0);
        chk("p2_done",  32'(bus.done),     32'h1);

        // Oversize length
        run_packet(16'h0002, 16'h0006, 8'h00, 8'h21, 1, 1'b1, 0, -1);
        chk("p3_err",   32'(bus.err),   32'h1);
        chk("p3_beats", 32'(rx.size()), 32'h0);

        // Checker silent -> timeout
        run_packet(16'h0003, 16'h0007, 8'h11, 8'd3, 99, 1'b1, 0, -1);
        chk("p4_err", 32'(bus.err),      32'h1);
        chk("p4_fwd", 32'(bus.fwd_flag), 32'h0);

        // Done on the very last timeout cycle wins; one later times out
        run_packet(16'h0004, 16'h0008, 8'h12, 8'd2, 15, 1'b1, 0, -1);
        chk("p5_err", 32'(bus.err),      32'h0);
        chk("p5_fwd", 32'(bus.fwd_flag), 32'h1);
        run_packet(16'h0004, 16'h0008, 8'h12, 8'd2, 16, 1'b1, 0, -1);
        chk("p6_err", 32'(bus.err), 32'h1);

        // Throttled sink with gapped input
        run_packet(16'h00AA, 16'h00BB, 8'h33, 8'd5, 0, 1'b1, 2, -1);
        chk("p7_beats", 32'(rx.size()), 32'h5);

        // Zero-length and maximum-length packets
        run_packet(16'h0010, 16'h0020, 8'h44, 8'd0, 3, 1'b1, 1, -1);
        chk("p8_done", 32'(bus.done), 32'h1);
        run_packet(16'h0011, 16'h0021, 8'h45, 8'd32, 4, 1'b1, 1, -1);
        chk("p9_beats", 32'(rx.size()), 32'd32);

        // Reset mid-payload, then a clean packet
        run_packet(16'h0055, 16'h0066, 8'h01, 8'd8, 1, 1'b1, 0, 3);
        run_packet(16'h1234, 16'h5678, 8'h9A, 8'd2, 0, 1'b1, 1, -1);
        chk("p10_src", 32'(bus.srcID),         32'h1234);
        chk("p10_dst", 32'(bus.destinationID), 32'h5678);

        for (int n = 0; n < 30; n++) begin
            rlen = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 32))
                                              : 8'($urandom_range(33, 40));
            run_packet(16'($urandom), 16'($urandom), 8'($urandom), rlen,
                       int'($urandom_range(0, 18)), 1'($urandom),
                       int'($urandom_range(0, 2)),
                       ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_pkt_header_parser
`default_nettype wire
